// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: op encodings, FSM states, counter width.
package jk_bank_arbiter_pkg;

   // Command ops; bit 1 drives J, bit 0 drives K for every masked bit.
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_RST  = 2'b01,
      OP_SET  = 2'b10,
      OP_TGL  = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } state_e;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the JK bank arbiter: packed per-requester commands plus status.
interface jk_bank_arbiter_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = 2
);
   logic [N-1:0]   req_valid;
   logic [2*N-1:0] req_op;
   logic [W*N-1:0] req_mask;
   logic [4*N-1:0] req_cnt;
   logic [N-1:0]   req_ready;
   logic [IW-1:0]  grant_id;
   logic           busy;
   logic           done;
   logic [W-1:0]   q;

   // Control agents drive commands and observe status.
   modport master (
      output req_valid, req_op, req_mask, req_cnt,
      input  req_ready, grant_id, busy, done, q
   );

   // The arbiter consumes commands and reports status.
   modport slave (
      input  req_valid, req_op, req_mask, req_cnt,
      output req_ready, grant_id, busy, done, q
   );
endinterface

// File: rtl/jk_bank_arbiter_reg_bank.sv
// W JK flip-flops, each a D flop fed with the classic JK next-state equation.
module jk_reg_bank #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] j,
   input  logic [W-1:0] k,
   output logic [W-1:0] q
);

   logic [W-1:0] d;

   // JK next state: 00 hold, 01 clear, 10 set, 11 toggle.
   always_comb begin
      d = (j & ~q) | (~k & q);
   end

   // Bank storage with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of statement order.
      if (rst) q <= '0;
      else     q <= d;
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences requester commands onto a shared JK bank.
module jk_bank_arbiter
   import jk_bank_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = 2
) (
   input  logic             clk,
   input  logic             rst,
   jk_bank_arbiter_if.slave bus
);

   state_e        state;
   logic [IW-1:0] ptr;
   op_e           cap_op;
   logic [W-1:0]  cap_mask;
   cnt_t          rem;

   logic          found;
   logic [IW-1:0] win;
   int            scan;
   op_e           win_op;
   logic [W-1:0]  win_mask;
   cnt_t          win_cnt;
   logic [W-1:0]  bank_j;
   logic [W-1:0]  bank_k;

   // Pick the first valid requester scanning from ptr with wrap-around.
   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      found = 1'b0;
      win   = '0;
      scan  = 0;
      for (int k = 0; k < N; k++) begin
         scan = int'(ptr) + k;
         if (scan >= N) scan = scan - N;
         if (!found && bus.req_valid[IW'(scan)]) begin
            found = 1'b1;
            win   = IW'(scan);
         end
      end
   end

   // Select the winner's payload fields.
   always_comb begin
      win_op   = OP_HOLD;
      win_mask = '0;
      win_cnt  = '0;
      for (int i = 0; i < N; i++) begin
         if (IW'(i) == win) begin
            win_op   = op_e'(bus.req_op[2*i +: 2]);
            win_mask = bus.req_mask[W*i +: W];
            win_cnt  = bus.req_cnt[4*i +: 4];
         end
      end
   end

   // One-hot accept pulse, only while idle and out of reset.
   always_comb begin
      bus.req_ready = '0;
      if (state == S_IDLE && found && !rst) bus.req_ready[win] = 1'b1;
   end

   // Sequencer: capture the winner, then apply it rem+1 cycles and pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         ptr          <= '0;
         cap_op       <= OP_HOLD;
         cap_mask     <= '0;
         rem          <= '0;
         bus.grant_id <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  cap_op       <= win_op;
                  cap_mask     <= win_mask;
                  rem          <= win_cnt;
                  bus.grant_id <= win;
                  ptr          <= (int'(win) == N - 1) ? '0 : win + IW'(1);
                  bus.busy     <= 1'b1;
                  state        <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (rem == '0) begin
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  rem <= rem - cnt_t'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Translate the captured op into per-bit J/K drives while executing.
   always_comb begin
      bank_j = '0;
      bank_k = '0;
      if (state == S_EXEC) begin
         case (cap_op)
            OP_RST:  bank_k = cap_mask;
            OP_SET:  bank_j = cap_mask;
            OP_TGL: begin
               bank_j = cap_mask;
               bank_k = cap_mask;
            end
            default: ;
         endcase
      end
   end

   jk_reg_bank #(.W(W)) u_bank (
      .clk (clk),
      .rst (rst),
      .j   (bank_j),
      .k   (bank_k),
      .q   (bus.q)
   );

endmodule
